id_stage: RTL and testbench
===========================

// Module: id_stage
// PURPOSE
//  Instruction-decode stage directly downstream of the fetch stage. Holds the IF/ID
//  pipeline latch, a 32x32 register file, load-use/branch hazard detection and
//  in-ID branch/jump resolution. Drives branch_or_pc/Jump/branch_addr/jump_addr back
//  to fetch and decoded operands/controls forward to EX (EX registers them).
// PARAMETERS
//  NOP_INST   32'h0000_0000  instruction word loaded on reset/flush (sll $0,$0,0)
//  RF_DEPTH   32             register count; reg 0 hard-wired to zero
// PORTS
//  clk           in   1   rising-edge clock
//  rst           in   1   reset, asynchronous, active-low
//  next_pc_if    in   32  PC+4 from fetch
//  inst_if       in   32  fetched instruction
//  ex_mem_read   in   1   instruction now in EX is a load
//  ex_reg_write  in   1   instruction now in EX writes a register
//  ex_dst        in   5   destination register of EX instruction
//  mem_mem_read  in   1   instruction now in MEM is a load
//  mem_dst       in   5   destination register of MEM instruction
//  wb_reg_write  in   1   write-back enable
//  wb_dst        in   5   write-back register
//  wb_data       in   32  write-back data
//  pc_stall      out  1   1 = fetch holds PC (and IF/ID holds)
//  branch_or_pc  out  1   taken branch redirect to fetch
//  Jump          out  1   jump redirect to fetch
//  branch_addr   out  32  branch target
//  jump_addr     out  32  jump target
//  rs_data, rt_data out 32  operand values to EX
//  imm_ext       out  32  sign-extended immediate
//  rs, rt, rd    out  5   register fields to EX
//  ctrl_reg_write, ctrl_mem_read, ctrl_mem_write, ctrl_alu_src, ctrl_reg_dst  out 1 each
//  ctrl_alu_op   out  2   00 add, 01 sub, 10 funct-decoded
// BEHAVIOUR
//  - IF/ID latch {inst_id, next_pc_id, valid_id}. rst low: inst_id=NOP_INST,
//    next_pc_id=0, valid_id=0 immediately. Register file cleared to 0 on reset.
//  - Each posedge: stall -> latch holds; else redirect (branch_or_pc|Jump) -> latch
//    loads NOP_INST, valid 0; else loads {inst_if, next_pc_if}, valid 1.
//  - Decode (opcode inst_id[31:26]): 000000 R-type, 100011 lw, 101011 sw, 000100 beq,
//    000101 bne, 001000 addi, 000010 j. Unknown opcode or valid_id=0: all ctrl_* = 0,
//    no redirect.
//  - Register file: write on posedge when wb_reg_write & wb_dst!=0. Reads are
//    combinational; if wb_reg_write & wb_dst!=0 & wb_dst==rs (or rt), the read returns
//    wb_data (same-cycle write-through). Reg 0 always reads 0.
//  - Load-use hazard: ex_mem_read & ex_dst!=0 & (ex_dst==rs | (rt used & ex_dst==rt)).
//    rt is used by R-type, sw, beq, bne.
//  - Branch hazard (beq/bne only): (ex_reg_write & ex_dst!=0 & ex_dst in {rs,rt}) or
//    (mem_mem_read & mem_dst!=0 & mem_dst in {rs,rt}).
//  - stall = valid_id & (load-use | branch hazard). pc_stall = stall. While stalled,
//    all ctrl_* = 0 (bubble into EX) and branch_or_pc = Jump = 0.
//  - branch_addr = next_pc_id + (imm_ext << 2), 32-bit wrap. beq taken if
//    rs_data==rt_data, bne if !=. jump_addr = {next_pc_id[31:28], inst_id[25:0], 2'b00}.
//  - branch_or_pc and Jump are mutually exclusive, combinational, same cycle as decode;
//    fetch consumes them at the next edge, this block flushes its latch at that edge.
//  - Reset mid-operation: latch and regfile clear asynchronously; outputs go to
//    bubble/no-redirect while rst is low.
// TESTING
//  - Reset: rst low mid-stream -> pc_stall=0, branch_or_pc=0, Jump=0, ctrl_*=0; $5 reads 0.
//  - WB bypass: wb writes $3=32'hDEAD_BEEF while ID decodes add $4,$3,$0 -> rs_data=DEADBEEF.
//  - Load-use: EX lw $2, ID add $4,$2,$1 -> pc_stall=1 one cycle, ctrl_*=0, latch held;
//    next cycle pc_stall=0.
//  - Taken beq $1,$1,+3 at next_pc_id=0x40 -> branch_or_pc=1, branch_addr=0x4C;
//    next cycle valid_id=0, ctrl_*=0.
//  - j 0x0000100 with next_pc_id=0x1000_0008 -> Jump=1, jump_addr=0x1000_0400.
//  - bne $2,$3 with EX addi writing $2 -> stall, no redirect, then resolves after.

Source files
------------

// File: rtl/id_stage.sv
// Decode stage: IF/ID latch, 32x32 register file with write-through,
// load-use / branch hazard stall and in-ID branch and jump resolution.
module id_stage #(
  parameter logic [31:0] NOP_INST = 32'h0000_0000,
  parameter int unsigned RF_DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] next_pc_if,
  input  logic [31:0] inst_if,
  input  logic        ex_mem_read,
  input  logic        ex_reg_write,
  input  logic [4:0]  ex_dst,
  input  logic        mem_mem_read,
  input  logic [4:0]  mem_dst,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_dst,
  input  logic [31:0] wb_data,
  output logic        pc_stall,
  output logic        branch_or_pc,
  output logic        Jump,
  output logic [31:0] branch_addr,
  output logic [31:0] jump_addr,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  output logic [31:0] imm_ext,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic        ctrl_reg_write,
  output logic        ctrl_mem_read,
  output logic        ctrl_mem_write,
  output logic        ctrl_alu_src,
  output logic        ctrl_reg_dst,
  output logic [1:0]  ctrl_alu_op
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_FN  = 2'b10;

  logic [31:0] inst_q, inst_d;
  logic [31:0] npc_q, npc_d;
  logic        valid_q, valid_d;

  logic [31:0] rf_q [RF_DEPTH];

  logic [5:0]  opcode;
  logic        is_r, is_lw, is_sw;
  logic        is_beq, is_bne, is_addi, is_j;
  logic        rt_used;
  logic        wb_we;
  logic        load_use, br_haz;
  logic        stall, redirect;
  logic        ops_eq, br_taken;

  logic        dec_reg_write, dec_mem_read;
  logic        dec_mem_write, dec_alu_src;
  logic        dec_reg_dst;
  logic [1:0]  dec_alu_op;

  // IF/ID latch
  always_comb begin
    inst_d  = inst_q;
    npc_d   = npc_q;
    valid_d = valid_q;
    if (stall) begin
      inst_d  = inst_q;
      npc_d   = npc_q;
      valid_d = valid_q;
    end else if (redirect) begin
      inst_d  = NOP_INST;
      npc_d   = '0;
      valid_d = 1'b0;
    end else begin
      inst_d  = inst_if;
      npc_d   = next_pc_if;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst_q  <= NOP_INST;
      npc_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      inst_q  <= inst_d;
      npc_q   <= npc_d;
      valid_q <= valid_d;
    end
  end

  // Register file; entry 0 is never written
  assign wb_we = wb_reg_write & (wb_dst != 5'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RF_DEPTH; i++)
        rf_q[i] <= '0;
    end else if (wb_we) begin
      rf_q[wb_dst] <= wb_data;
    end
  end

  assign opcode  = inst_q[31:26];
  assign rs      = inst_q[25:21];
  assign rt      = inst_q[20:16];
  assign rd      = inst_q[15:11];
  assign imm_ext = {{16{inst_q[15]}}, inst_q[15:0]};

  always_comb begin
    rs_data = '0;
    if (rs == 5'd0)
      rs_data = '0;
    else if (wb_we && wb_dst == rs)
      rs_data = wb_data;
    else
      rs_data = rf_q[rs];
  end

  always_comb begin
    rt_data = '0;
    if (rt == 5'd0)
      rt_data = '0;
    else if (wb_we && wb_dst == rt)
      rt_data = wb_data;
    else
      rt_data = rf_q[rt];
  end

  assign is_r    = valid_q & (opcode == OP_R);
  assign is_lw   = valid_q & (opcode == OP_LW);
  assign is_sw   = valid_q & (opcode == OP_SW);
  assign is_beq  = valid_q & (opcode == OP_BEQ);
  assign is_bne  = valid_q & (opcode == OP_BNE);
  assign is_addi = valid_q & (opcode == OP_ADDI);
  assign is_j    = valid_q & (opcode == OP_J);

  always_comb begin
    dec_reg_write = 1'b0;
    dec_mem_read  = 1'b0;
    dec_mem_write = 1'b0;
    dec_alu_src   = 1'b0;
    dec_reg_dst   = 1'b0;
    dec_alu_op    = ALU_ADD;
    unique case (1'b1)
      is_r: begin
        dec_reg_write = 1'b1;
        dec_reg_dst   = 1'b1;
        dec_alu_op    = ALU_FN;
      end
      is_lw: begin
        dec_reg_write = 1'b1;
        dec_mem_read  = 1'b1;
        dec_alu_src   = 1'b1;
      end
      is_sw: begin
        dec_mem_write = 1'b1;
        dec_alu_src   = 1'b1;
      end
      is_beq, is_bne: begin
        dec_alu_op = ALU_SUB;
      end
      is_addi: begin
        dec_reg_write = 1'b1;
        dec_alu_src   = 1'b1;
      end
      default: begin
        dec_reg_write = 1'b0;
      end
    endcase
  end

  // Hazards
  assign rt_used  = is_r | is_sw | is_beq | is_bne;

  assign load_use = ex_mem_read & (ex_dst != 5'd0) &
                    ((ex_dst == rs) | (rt_used & (ex_dst == rt)));

  assign br_haz   = (is_beq | is_bne) & (
                    (ex_reg_write & (ex_dst != 5'd0) &
                     ((ex_dst == rs) | (ex_dst == rt))) |
                    (mem_mem_read & (mem_dst != 5'd0) &
                     ((mem_dst == rs) | (mem_dst == rt))));

  assign stall    = valid_q & (load_use | br_haz);
  assign pc_stall = stall;

  // Branch and jump resolution
  assign ops_eq   = (rs_data == rt_data);
  assign br_taken = (is_beq & ops_eq) | (is_bne & ~ops_eq);

  assign branch_addr  = npc_q + {imm_ext[29:0], 2'b00};
  assign jump_addr    = {npc_q[31:28], inst_q[25:0], 2'b00};

  assign branch_or_pc = br_taken & ~stall;
  assign Jump         = is_j & ~stall;
  assign redirect     = branch_or_pc | Jump;

  assign ctrl_reg_write = dec_reg_write & ~stall;
  assign ctrl_mem_read  = dec_mem_read  & ~stall;
  assign ctrl_mem_write = dec_mem_write & ~stall;
  assign ctrl_alu_src   = dec_alu_src   & ~stall;
  assign ctrl_reg_dst   = dec_reg_dst   & ~stall;
  assign ctrl_alu_op    = stall ? ALU_ADD : dec_alu_op;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: reset, write-through, hazards,
// branch/jump redirect and flush.
module tb_id_stage;

  logic        clk;
  logic        rst;
  logic [31:0] next_pc_if;
  logic [31:0] inst_if;
  logic        ex_mem_read;
  logic        ex_reg_write;
  logic [4:0]  ex_dst;
  logic        mem_mem_read;
  logic [4:0]  mem_dst;
  logic        wb_reg_write;
  logic [4:0]  wb_dst;
  logic [31:0] wb_data;
  logic        pc_stall;
  logic        branch_or_pc;
  logic        Jump;
  logic [31:0] branch_addr;
  logic [31:0] jump_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] imm_ext;
  logic [4:0]  rs, rt, rd;
  logic        ctrl_reg_write, ctrl_mem_read;
  logic        ctrl_mem_write, ctrl_alu_src;
  logic        ctrl_reg_dst;
  logic [1:0]  ctrl_alu_op;

  int checks   = 0;
  int failures = 0;

  id_stage dut (
    .clk            (clk),
    .rst            (rst),
    .next_pc_if     (next_pc_if),
    .inst_if        (inst_if),
    .ex_mem_read    (ex_mem_read),
    .ex_reg_write   (ex_reg_write),
    .ex_dst         (ex_dst),
    .mem_mem_read   (mem_mem_read),
    .mem_dst        (mem_dst),
    .wb_reg_write   (wb_reg_write),
    .wb_dst         (wb_dst),
    .wb_data        (wb_data),
    .pc_stall       (pc_stall),
    .branch_or_pc   (branch_or_pc),
    .Jump           (Jump),
    .branch_addr    (branch_addr),
    .jump_addr      (jump_addr),
    .rs_data        (rs_data),
    .rt_data        (rt_data),
    .imm_ext        (imm_ext),
    .rs             (rs),
    .rt             (rt),
    .rd             (rd),
    .ctrl_reg_write (ctrl_reg_write),
    .ctrl_mem_read  (ctrl_mem_read),
    .ctrl_mem_write (ctrl_mem_write),
    .ctrl_alu_src   (ctrl_alu_src),
    .ctrl_reg_dst   (ctrl_reg_dst),
    .ctrl_alu_op    (ctrl_alu_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {reg_write, mem_read, mem_write, alu_src, reg_dst, alu_op}
  logic [6:0] ctrl;
  assign ctrl = {ctrl_reg_write, ctrl_mem_read, ctrl_mem_write,
                 ctrl_alu_src, ctrl_reg_dst, ctrl_alu_op};

  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_R    = 7'b1000110;
  localparam logic [6:0] C_BR   = 7'b0000001;

  localparam logic [31:0] ADD_4_3_0  = 32'h0060_2020;
  localparam logic [31:0] ADD_4_2_1  = 32'h0041_2020;
  localparam logic [31:0] ADD_4_5_0  = 32'h00A0_2020;
  localparam logic [31:0] BEQ_1_1_P3 = 32'h1021_0003;
  localparam logic [31:0] BEQ_0_0_M1 = 32'h1000_FFFF;
  localparam logic [31:0] J_100      = 32'h0800_0100;
  localparam logic [31:0] BNE_2_3_P1 = 32'h1443_0001;
  localparam logic [31:0] BAD_OP     = 32'hFFFF_FFFF;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_clear();
    ex_mem_read  = 1'b0;
    ex_reg_write = 1'b0;
    ex_dst       = 5'd0;
    mem_mem_read = 1'b0;
    mem_dst      = 5'd0;
  endtask

  initial begin
    rst          = 1'b0;
    next_pc_if   = '0;
    inst_if      = '0;
    wb_reg_write = 1'b0;
    wb_dst       = '0;
    wb_data      = '0;
    ex_clear();
    #2;
    chk("rst_stall", {31'd0, pc_stall}, 32'd0);
    chk("rst_br", {31'd0, branch_or_pc}, 32'd0);
    chk("rst_jump", {31'd0, Jump}, 32'd0);
    chk("rst_ctrl", {25'd0, ctrl}, {25'd0, C_NONE});
    tick();
    rst = 1'b1;

    // preload $1=0x11, $2=0x22, $5=0x77
    wb_reg_write = 1'b1;
    wb_dst = 5'd1; wb_data = 32'h11; tick();
    wb_dst = 5'd2; wb_data = 32'h22; tick();
    wb_dst = 5'd5; wb_data = 32'h77;
    inst_if = ADD_4_3_0; next_pc_if = 32'h10;
    tick();

    // write-through of $3 while add $4,$3,$0 is in ID
    wb_dst = 5'd3; wb_data = 32'hDEAD_BEEF;
    ex_reg_write = 1'b1; ex_dst = 5'd3;
    inst_if = ADD_4_2_1; next_pc_if = 32'h14;
    #1;
    chk("bypass_rs", rs_data, 32'hDEAD_BEEF);
    chk("bypass_rt", rt_data, 32'h0);
    chk("add_ctrl", {25'd0, ctrl}, {25'd0, C_R});
    chk("add_no_stall", {31'd0, pc_stall}, 32'd0);
    tick();
    wb_reg_write = 1'b0;

    // add $4,$2,$1 in ID behind lw $2 in EX
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_dst = 5'd2;
    inst_if = BAD_OP;
    #1;
    chk("lu_stall", {31'd0, pc_stall}, 32'd1);
    chk("lu_ctrl", {25'd0, ctrl}, {25'd0, C_NONE});
    chk("lu_rd", {27'd0, rd}, 32'd4);
    tick();
    ex_clear();
    #1;
    chk("lu_release", {31'd0, pc_stall}, 32'd0);
    chk("lu_held_ctrl", {25'd0, ctrl}, {25'd0, C_R});
    chk("lu_held_rs", rs_data, 32'h22);
    chk("lu_held_rt", rt_data, 32'h11);
    inst_if = BEQ_1_1_P3; next_pc_if = 32'h40;
    tick();

    // beq $1,$1,+3 at next_pc_id=0x40
    inst_if = ADD_4_3_0; next_pc_if = 32'h44;
    #1;
    chk("beq_taken", {31'd0, branch_or_pc}, 32'd1);
    chk("beq_nojump", {31'd0, Jump}, 32'd0);
    chk("beq_addr", branch_addr, 32'h0000_004C);
    chk("beq_ctrl", {25'd0, ctrl}, {25'd0, C_BR});
    tick();
    #1;
    chk("flush_ctrl", {25'd0, ctrl}, {25'd0, C_NONE});
    chk("flush_br", {31'd0, branch_or_pc}, 32'd0);
    chk("flush_stall", {31'd0, pc_stall}, 32'd0);
    inst_if = J_100; next_pc_if = 32'h1000_0008;
    tick();

    // j 0x100
    inst_if = ADD_4_3_0; next_pc_if = 32'h1000_000C;
    #1;
    chk("j_jump", {31'd0, Jump}, 32'd1);
    chk("j_addr", jump_addr, 32'h1000_0400);
    chk("j_nobr", {31'd0, branch_or_pc}, 32'd0);
    chk("j_ctrl", {25'd0, ctrl}, {25'd0, C_NONE});
    tick();
    #1;
    chk("j_flush", {31'd0, Jump}, 32'd0);
    inst_if = BNE_2_3_P1; next_pc_if = 32'h80;
    tick();

    // bne $2,$3 behind addi $2 in EX, then lw $3 in MEM
    ex_reg_write = 1'b1; ex_dst = 5'd2;
    inst_if = BAD_OP;
    #1;
    chk("bne_stall_ex", {31'd0, pc_stall}, 32'd1);
    chk("bne_no_redir", {31'd0, branch_or_pc}, 32'd0);
    chk("bne_ctrl", {25'd0, ctrl}, {25'd0, C_NONE});
    tick();
    ex_clear();
    mem_mem_read = 1'b1; mem_dst = 5'd3;
    #1;
    chk("bne_stall_mem", {31'd0, pc_stall}, 32'd1);
    tick();
    ex_clear();
    inst_if = ADD_4_3_0;
    #1;
    chk("bne_resume", {31'd0, pc_stall}, 32'd0);
    chk("bne_taken", {31'd0, branch_or_pc}, 32'd1);
    chk("bne_addr", branch_addr, 32'h0000_0084);
    tick();

    // beq $0,$0,-1 at next_pc 0x4; write to $0 is ignored
    inst_if = BEQ_0_0_M1; next_pc_if = 32'h4;
    tick();
    wb_reg_write = 1'b1; wb_dst = 5'd0; wb_data = 32'h55;
    #1;
    chk("r0_read", rs_data, 32'h0);
    chk("neg_addr", branch_addr, 32'h0000_0000);
    chk("neg_taken", {31'd0, branch_or_pc}, 32'd1);
    tick();
    wb_reg_write = 1'b0;
    inst_if = ADD_4_5_0; next_pc_if = 32'h20;
    tick();

    // reset while add $4,$5,$0 is stalled by lw $5
    ex_mem_read = 1'b1; ex_dst = 5'd5;
    #1;
    chk("pre_rst_rs5", rs_data, 32'h77);
    chk("pre_rst_stall", {31'd0, pc_stall}, 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_stall", {31'd0, pc_stall}, 32'd0);
    chk("mid_rst_br", {31'd0, branch_or_pc | Jump}, 32'd0);
    chk("mid_rst_ctrl", {25'd0, ctrl}, {25'd0, C_NONE});
    tick();
    rst = 1'b1;
    ex_clear();
    tick();
    #1;
    chk("post_rst_rs5", rs_data, 32'h0);
    chk("post_rst_ctrl", {25'd0, ctrl}, {25'd0, C_R});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
